int_stim_gen: RTL and testbench

Parametrised interrupt stimulus generator for the CPU system testbench and FPGA bring-up harness. It watches the CPU's macroscopic PC and raises up to N_CH independent interrupt lines after programmable trigger PCs are reached. Each line holds until the CPU writes the matching acknowledge address. It adds multi-channel support, per-channel delay and fire-count limits, and re-arm protection to single-shot interrupt injection, and sits between the `mips` core's observation ports and its `interrupt` input.

---
 rtl/int_stim_gen.sv | 122 ++++++++++++
 tb/tb_int_stim_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/int_stim_gen.sv
// Multi-channel interrupt stimulus generator: raises per-channel interrupt lines when the
// CPU PC reaches programmable trigger addresses. Each line is held until the CPU acknowledges it.
module int_stim_gen #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned FIRE_W   = 4,
  parameter logic [31:0] ACK_BASE = 32'h0000_7F20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              macroscopic_pc,
  input  logic [31:0]              m_int_addr,
  input  logic [3:0]               m_int_byteen,
  input  logic [N_CH-1:0]          cfg_en,
  input  logic [N_CH*32-1:0]       cfg_trig_pc,
  input  logic [N_CH*DLY_W-1:0]    cfg_delay,
  input  logic [N_CH*FIRE_W-1:0]   cfg_fires,
  output logic [N_CH-1:0]          irq_vec,
  output logic                     interrupt,
  output logic [N_CH*FIRE_W-1:0]   fire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ASSERT,
    S_REARM
  } state_e;

  localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);
  localparam logic [FIRE_W-1:0] FIRE_ONE = FIRE_W'(1);

  logic [31:0] pc_word;
  logic [31:0] addr_word;
  logic        wr_valid;

  assign pc_word   = macroscopic_pc & ~32'h3;
  assign addr_word = m_int_addr & ~32'h3;
  assign wr_valid  = |m_int_byteen;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [31:0] ACK_ADDR = ACK_BASE + 32'(4 * gi);

    state_e            state_q;
    logic [DLY_W-1:0]  cnt_q;
    logic [FIRE_W-1:0] fire_q;
    logic [FIRE_W-1:0] fire_d;
    logic              irq_q;

    logic              en;
    logic [DLY_W-1:0]  dly;
    logic [FIRE_W-1:0] fire_lim;
    logic              match;
    logic              ack;
    logic              budget_ok;

    assign en        = cfg_en[gi];
    assign dly       = cfg_delay[gi*DLY_W +: DLY_W];
    assign fire_lim  = cfg_fires[gi*FIRE_W +: FIRE_W];
    assign match     = pc_word == (cfg_trig_pc[gi*32 +: 32] & ~32'h3);
    assign ack       = wr_valid && (addr_word == ACK_ADDR);
    assign budget_ok = (fire_lim == '0) || (fire_q < fire_lim);
    assign fire_d    = (fire_q == '1) ? fire_q : fire_q + FIRE_ONE;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        fire_q  <= '0;
        irq_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (en && match && budget_ok) begin
              if (dly == '0) begin
                state_q <= S_ASSERT;
                irq_q   <= 1'b1;
              end else begin
                state_q <= S_WAIT;
                cnt_q   <= dly - DLY_ONE;
              end
            end
          end
          S_WAIT: begin
            if (!en) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == '0) begin
              state_q <= S_ASSERT;
              irq_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - DLY_ONE;
            end
          end
          // Line is held regardless of enable or PC; only the matching ack releases it.
          S_ASSERT: begin
            if (ack) begin
              state_q <= S_REARM;
              irq_q   <= 1'b0;
              fire_q  <= fire_d;
            end
          end
          S_REARM: begin
            if (!match) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        endcase
      end
    end

    assign irq_vec[gi]                   = irq_q;
    assign fire_cnt[gi*FIRE_W +: FIRE_W] = fire_q;
  end

  assign interrupt = |irq_vec;

endmodule

// File: tb/tb_int_stim_gen.sv
// Table-driven bench for int_stim_gen (N_CH=2): vectors are queued as expectations when
// driven and compared one edge later; asynchronous reset is checked by hand.
module tb_int_stim_gen;

  logic        clk;
  logic        reset;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic [1:0]  cfg_en;
  logic [63:0] cfg_trig_pc;
  logic [15:0] cfg_delay;
  logic [7:0]  cfg_fires;
  logic [1:0]  irq_vec;
  logic        interrupt;
  logic [7:0]  fire_cnt;

  int_stim_gen #(
    .N_CH    (2),
    .DLY_W   (8),
    .FIRE_W  (4),
    .ACK_BASE(32'h0000_7F20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr    (m_int_addr),
    .m_int_byteen  (m_int_byteen),
    .cfg_en        (cfg_en),
    .cfg_trig_pc   (cfg_trig_pc),
    .cfg_delay     (cfg_delay),
    .cfg_fires     (cfg_fires),
    .irq_vec       (irq_vec),
    .interrupt     (interrupt),
    .fire_cnt      (fire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [1:0]  en;
    logic [1:0]  irq;
    logic [3:0]  f0;
    logic [3:0]  f1;
  } vec_t;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    step  = 0;
  string phase = "init";

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] addr,
                              input logic [3:0] be, input logic [1:0] en,
                              input logic [1:0] irq, input logic [3:0] f0,
                              input logic [3:0] f1);
    vec_t v;
    v.pc = pc; v.addr = addr; v.be = be; v.en = en;
    v.irq = irq; v.f0 = f0; v.f1 = f1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s/%s step %0d: got %0h, expected %0h", phase, name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    macroscopic_pc = v.pc;
    m_int_addr     = v.addr;
    m_int_byteen   = v.be;
    cfg_en         = v.en;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    step++;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("irq_vec",   32'(irq_vec),   32'(e.irq));
      check("interrupt", 32'(interrupt), 32'(|e.irq));
      check("fire_cnt",  32'(fire_cnt),  32'({e.f1, e.f0}));
    end
  endtask

  task automatic run_table(input string name);
    phase = name;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  // Pulses reset mid-cycle and checks outputs clear before the next clock edge.
  task automatic async_reset(input string name);
    phase = name;
    #2;
    reset = 1'b0;
    #1;
    check("rst_irq_vec",   32'(irq_vec),   32'd0);
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_fire_cnt",  32'(fire_cnt),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] f0;
    reset          = 1'b0;
    macroscopic_pc = 32'h0;
    m_int_addr     = 32'h0;
    m_int_byteen   = 4'h0;
    cfg_en         = 2'b01;
    cfg_trig_pc    = {32'h0000_3040, 32'h0000_301C};
    cfg_delay      = {8'd5, 8'd0};
    cfg_fires      = {4'd0, 4'd1};

    #12;
    phase = "reset";
    check("reset_irq_vec",   32'(irq_vec),   32'd0);
    check("reset_interrupt", 32'(interrupt), 32'd0);
    check("reset_fire_cnt",  32'(fire_cnt),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fire and ack, then reset must clear fire_cnt and restore the budget.
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b01, 4'd0, 4'd0));
    tbl.push_back(mk(32'h1000, 32'h7F20, 4'hF, 2'b01, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0,    4'h0, 2'b01, 2'b00, 4'd1, 4'd0));
    run_table("prefire");
    async_reset("reset_clears_count");

    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b01, 4'd0, 4'd0));
    run_table("refire_after_reset");
    async_reset("reset_while_asserted");

    tbl.push_back(mk(32'h1000, 32'h0,    4'h0, 2'b01, 2'b00, 4'd0, 4'd0));
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b01, 4'd0, 4'd0));
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b01, 4'd0, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0,    4'h0, 2'b00, 2'b01, 4'd0, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h7F20, 4'hF, 2'b01, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0,    4'h0, 2'b01, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h301F, 32'h0,    4'h0, 2'b01, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h7F20, 4'hF, 2'b01, 2'b00, 4'd1, 4'd0));
    run_table("first_fire");

    tbl.push_back(mk(32'h3040, 32'h0, 4'h0, 2'b10, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0, 4'h0, 2'b10, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0, 4'h0, 2'b10, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0, 4'h0, 2'b00, 2'b00, 4'd1, 4'd0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(32'h2000, 32'h0, 4'h0, 2'b10, 2'b00, 4'd1, 4'd0));
    run_table("abort");

    tbl.push_back(mk(32'h3040, 32'h0, 4'h0, 2'b10, 2'b00, 4'd1, 4'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(32'h2000, 32'h0, 4'h0, 2'b10, 2'b00, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0,    4'h0, 2'b10, 2'b10, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h0,    4'h0, 2'b10, 2'b10, 4'd1, 4'd0));
    tbl.push_back(mk(32'h2000, 32'h7F24, 4'h1, 2'b10, 2'b00, 4'd1, 4'd1));
    tbl.push_back(mk(32'h2000, 32'h0,    4'h0, 2'b10, 2'b00, 4'd1, 4'd1));
    run_table("delay5");

    cfg_fires = {4'd0, 4'd0};
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b01, 4'd1, 4'd1));
    tbl.push_back(mk(32'h301C, 32'h7F20, 4'hF, 2'b01, 2'b00, 4'd2, 4'd1));
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b00, 4'd2, 4'd1));
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b00, 4'd2, 4'd1));
    tbl.push_back(mk(32'h1000, 32'h0,    4'h0, 2'b01, 2'b00, 4'd2, 4'd1));
    run_table("ack_and_match");

    f0 = 4'd2;
    for (int i = 0; i < 20; i++) begin
      tbl.push_back(mk(32'h301C, 32'h0, 4'h0, 2'b01, 2'b01, f0, 4'd1));
      f0 = (f0 == 4'd15) ? f0 : f0 + 4'd1;
      tbl.push_back(mk(32'h301C, 32'h7F20, 4'hF, 2'b01, 2'b00, f0, 4'd1));
      tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b01, 2'b00, f0, 4'd1));
      tbl.push_back(mk(32'h1000, 32'h0,    4'h0, 2'b01, 2'b00, f0, 4'd1));
    end
    run_table("unlimited_saturate");

    cfg_trig_pc = {32'h0000_301C, 32'h0000_301C};
    cfg_delay   = {8'd0, 8'd0};
    tbl.push_back(mk(32'h301C, 32'h0,    4'h0, 2'b11, 2'b11, 4'd15, 4'd1));
    tbl.push_back(mk(32'h1000, 32'h7F24, 4'h1, 2'b11, 2'b01, 4'd15, 4'd2));
    tbl.push_back(mk(32'h1000, 32'h7F28, 4'hF, 2'b11, 2'b01, 4'd15, 4'd2));
    tbl.push_back(mk(32'h1000, 32'h7F20, 4'h0, 2'b11, 2'b01, 4'd15, 4'd2));
    tbl.push_back(mk(32'h1000, 32'h7F24, 4'hF, 2'b11, 2'b01, 4'd15, 4'd2));
    tbl.push_back(mk(32'h1000, 32'h7F22, 4'h2, 2'b11, 2'b00, 4'd15, 4'd2));
    tbl.push_back(mk(32'h1000, 32'h0,    4'h0, 2'b11, 2'b00, 4'd15, 4'd2));
    run_table("cross_ack");

    phase = "end";
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
